// File: rtl/mips_pkg.sv
// Shared decode constants and the ID control bundle for the id_stage slice.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    link;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle: id_stage drives (master), execute consumes (slave).
interface id_stage_if;

    logic [31:0] EX_RsData;
    logic [31:0] EX_RtData;
    logic [31:0] EX_Imm;
    logic [31:0] EX_PCplus4;
    logic [4:0]  EX_Rs;
    logic [4:0]  EX_Rt;
    logic [4:0]  EX_WriteReg;
    logic [3:0]  EX_ALUOp;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_MemToReg;
    logic        EX_ALUSrc;
    logic        EX_Link;

    modport master (
        output EX_RsData, EX_RtData, EX_Imm, EX_PCplus4,
        output EX_Rs, EX_Rt, EX_WriteReg, EX_ALUOp,
        output EX_RegWrite, EX_MemRead, EX_MemWrite,
        output EX_MemToReg, EX_ALUSrc, EX_Link
    );

    modport slave (
        input EX_RsData, EX_RtData, EX_Imm, EX_PCplus4,
        input EX_Rs, EX_Rt, EX_WriteReg, EX_ALUOp,
        input EX_RegWrite, EX_MemRead, EX_MemWrite,
        input EX_MemToReg, EX_ALUSrc, EX_Link
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: 2 read, 1 write, write-first reads, r0 hardwired to 0.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (we && waddr == raddr_a) rdata_a = wdata;
        if (we && waddr == raddr_b) rdata_b = wdata;
        if (raddr_a == 5'd0) rdata_a = '0;
        if (raddr_b == 5'd0) rdata_b = '0;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: regfile, decode, hazard stalls, branch/jump resolve, ID/EX register.
// Define ID_BRANCH_FWD_EN to bypass MEM_ALUOut into branch/jr operands instead of stalling.
module id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] ID_Instruction,
    input  logic [31:0] ID_PCplus4,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_WriteData,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    input  logic [31:0] MEM_ALUOut,
    output logic [1:0]  IF_PCSrc,
    output logic [31:0] ID_JumpAddr,
    output logic [31:0] ID_BranchAddr,
    output logic [31:0] ID_RsData,
    output logic        IF_PCWrite,
    output logic        IF_Write,
    output logic        IF_Flush,
    id_stage_if.master  ex
);

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dst;
    logic [15:0] imm;
    logic [31:0] rf_rs, rf_rt, rs_val, rt_val, imm_ext;
    logic        is_r, i_add, i_sub, i_and, i_or, i_slt, i_sll, i_srl, i_jr;
    logic        i_addi, i_slti, i_andi, i_ori, i_lui, i_lw, i_sw;
    logic        i_beq, i_bne, i_j, i_jal, r_alu, i_alui, i_br;
    logic        use_rs, use_rt, zext;
    logic        mem_alu_rs, mem_alu_rt, mem_alu_stall;
    logic        load_use, br_stall, stall;
    ctrl_t       ctl;

    assign op  = ID_Instruction[31:26];
    assign rs  = ID_Instruction[25:21];
    assign rt  = ID_Instruction[20:16];
    assign rd  = ID_Instruction[15:11];
    assign fn  = ID_Instruction[5:0];
    assign imm = ID_Instruction[15:0];

    // All-zero word is sll $0 by encoding but must behave as a pure NOP.
    assign is_r   = op == OP_RTYPE && ID_Instruction != NOP;
    assign i_add  = is_r && fn == FN_ADD;
    assign i_sub  = is_r && fn == FN_SUB;
    assign i_and  = is_r && fn == FN_AND;
    assign i_or   = is_r && fn == FN_OR;
    assign i_slt  = is_r && fn == FN_SLT;
    assign i_sll  = is_r && fn == FN_SLL;
    assign i_srl  = is_r && fn == FN_SRL;
    assign i_jr   = is_r && fn == FN_JR;
    assign i_addi = op == OP_ADDI;
    assign i_slti = op == OP_SLTI;
    assign i_andi = op == OP_ANDI;
    assign i_ori  = op == OP_ORI;
    assign i_lui  = op == OP_LUI;
    assign i_lw   = op == OP_LW;
    assign i_sw   = op == OP_SW;
    assign i_beq  = op == OP_BEQ;
    assign i_bne  = op == OP_BNE;
    assign i_j    = op == OP_J;
    assign i_jal  = op == OP_JAL;
    assign r_alu  = i_add | i_sub | i_and | i_or | i_slt | i_sll | i_srl;
    assign i_alui = i_addi | i_slti | i_andi | i_ori | i_lui;
    assign i_br   = i_beq | i_bne;

    reg_file u_rf (
        .clk     (Clock),
        .rst     (Reset),
        .we      (WB_RegWrite),
        .waddr   (WB_WriteReg),
        .wdata   (WB_WriteData),
        .raddr_a (rs),
        .rdata_a (rf_rs),
        .raddr_b (rt),
        .rdata_b (rf_rt)
    );

    always_comb begin
        ctl    = CTRL_NOP;
        dst    = 5'd0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        zext   = 1'b0;
        unique case (1'b1)
            r_alu: begin
                ctl.reg_write = 1'b1;
                dst    = rd;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            i_jr: use_rs = 1'b1;
            i_alui: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                dst    = rt;
                use_rs = !i_lui;
                zext   = i_andi | i_ori | i_lui;
            end
            i_lw: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_read   = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.alu_src    = 1'b1;
                dst    = rt;
                use_rs = 1'b1;
            end
            i_sw: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            i_br: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            i_jal: begin
                ctl.reg_write = 1'b1;
                ctl.link      = 1'b1;
                dst = 5'd31;
            end
            default: ;
        endcase
        unique case (1'b1)
            i_sub, i_br:    ctl.alu_op = ALU_SUB;
            i_and, i_andi:  ctl.alu_op = ALU_AND;
            i_or, i_ori:    ctl.alu_op = ALU_OR;
            i_slt, i_slti:  ctl.alu_op = ALU_SLT;
            i_sll:          ctl.alu_op = ALU_SLL;
            i_srl:          ctl.alu_op = ALU_SRL;
            i_lui:          ctl.alu_op = ALU_LUI;
            default:        ctl.alu_op = ALU_ADD;
        endcase
    end

    assign imm_ext = zext ? {16'h0, imm} : {{16{imm[15]}}, imm};

    assign mem_alu_rs = MEM_RegWrite && !MEM_MemRead
                        && MEM_WriteReg != 5'd0 && MEM_WriteReg == rs;
    assign mem_alu_rt = MEM_RegWrite && !MEM_MemRead
                        && MEM_WriteReg != 5'd0 && MEM_WriteReg == rt;

`ifdef ID_BRANCH_FWD_EN
    assign rs_val        = mem_alu_rs ? MEM_ALUOut : rf_rs;
    assign rt_val        = mem_alu_rt ? MEM_ALUOut : rf_rt;
    assign mem_alu_stall = 1'b0;
`else
    logic unused_mem_aluout;
    assign unused_mem_aluout = ^MEM_ALUOut;
    assign rs_val        = rf_rs;
    assign rt_val        = rf_rt;
    assign mem_alu_stall = mem_alu_rs || (i_br && mem_alu_rt);
`endif

    assign load_use = ex.EX_MemRead && ex.EX_WriteReg != 5'd0
                      && ((use_rs && ex.EX_WriteReg == rs)
                      ||  (use_rt && ex.EX_WriteReg == rt));

    assign br_stall = (i_br || i_jr) && (
          (ex.EX_RegWrite && ex.EX_WriteReg != 5'd0 && ex.EX_WriteReg == rs)
       || (i_br && ex.EX_RegWrite && ex.EX_WriteReg != 5'd0
                && ex.EX_WriteReg == rt)
       || (MEM_MemRead && MEM_WriteReg == rs)
       || (i_br && MEM_MemRead && MEM_WriteReg == rt)
       || mem_alu_stall);

    assign stall = !Reset && (load_use || br_stall);

    assign ID_RsData     = rs_val;
    assign ID_JumpAddr   = {ID_PCplus4[31:28], ID_Instruction[25:0], 2'b00};
    assign ID_BranchAddr = ID_PCplus4 + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        IF_PCSrc   = PCSRC_SEQ;
        IF_PCWrite = !stall;
        IF_Write   = !stall;
        IF_Flush   = 1'b0;
        if (!Reset && !stall) begin
            unique case (1'b1)
                i_beq && rs_val == rt_val,
                i_bne && rs_val != rt_val: begin
                    IF_PCSrc = PCSRC_BR;
                    IF_Flush = 1'b1;
                end
                i_j, i_jal: begin
                    IF_PCSrc = PCSRC_JMP;
                    IF_Flush = 1'b1;
                end
                i_jr: begin
                    IF_PCSrc = PCSRC_JR;
                    IF_Flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ex.EX_RsData   <= '0;
            ex.EX_RtData   <= '0;
            ex.EX_Imm      <= '0;
            ex.EX_PCplus4  <= RESET_PC;
            ex.EX_Rs       <= '0;
            ex.EX_Rt       <= '0;
            ex.EX_WriteReg <= '0;
            ex.EX_ALUOp    <= '0;
            ex.EX_RegWrite <= 1'b0;
            ex.EX_MemRead  <= 1'b0;
            ex.EX_MemWrite <= 1'b0;
            ex.EX_MemToReg <= 1'b0;
            ex.EX_ALUSrc   <= 1'b0;
            ex.EX_Link     <= 1'b0;
        end else begin
            ex.EX_RsData   <= rs_val;
            ex.EX_RtData   <= rt_val;
            ex.EX_Imm      <= imm_ext;
            ex.EX_PCplus4  <= ID_PCplus4;
            ex.EX_Rs       <= stall ? 5'd0 : rs;
            ex.EX_Rt       <= stall ? 5'd0 : rt;
            ex.EX_WriteReg <= stall ? 5'd0 : dst;
            ex.EX_ALUOp    <= stall ? 4'd0 : ctl.alu_op;
            ex.EX_RegWrite <= !stall && ctl.reg_write;
            ex.EX_MemRead  <= !stall && ctl.mem_read;
            ex.EX_MemWrite <= !stall && ctl.mem_write;
            ex.EX_MemToReg <= !stall && ctl.mem_to_reg;
            ex.EX_ALUSrc   <= !stall && ctl.alu_src;
            ex.EX_Link     <= !stall && ctl.link;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage (decode, hazards, redirects).
module tb_id_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] ID_Instruction, ID_PCplus4;
    logic        WB_RegWrite, MEM_RegWrite, MEM_MemRead;
    logic [4:0]  WB_WriteReg, MEM_WriteReg;
    logic [31:0] WB_WriteData, MEM_ALUOut;
    logic [1:0]  IF_PCSrc;
    logic [31:0] ID_JumpAddr, ID_BranchAddr, ID_RsData;
    logic        IF_PCWrite, IF_Write, IF_Flush;
    int          checks = 0;
    int          errors = 0;

    id_stage_if ex_bus ();

    id_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .ID_Instruction (ID_Instruction),
        .ID_PCplus4     (ID_PCplus4),
        .WB_RegWrite    (WB_RegWrite),
        .WB_WriteReg    (WB_WriteReg),
        .WB_WriteData   (WB_WriteData),
        .MEM_RegWrite   (MEM_RegWrite),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_WriteReg   (MEM_WriteReg),
        .MEM_ALUOut     (MEM_ALUOut),
        .IF_PCSrc       (IF_PCSrc),
        .ID_JumpAddr    (ID_JumpAddr),
        .ID_BranchAddr  (ID_BranchAddr),
        .ID_RsData      (ID_RsData),
        .IF_PCWrite     (IF_PCWrite),
        .IF_Write       (IF_Write),
        .IF_Flush       (IF_Flush),
        .ex             (ex_bus.master)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] rtype(int s, int t, int d, int f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
    endfunction

    function automatic logic [31:0] itype(int o, int s, int t, int i);
        return {6'(o), 5'(s), 5'(t), 16'(i)};
    endfunction

    function automatic logic [31:0] jtype(int o, int a);
        return {6'(o), 26'(a)};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ID_Instruction = jtype(2, 26'h40);
        ID_PCplus4 = 32'h4;
        WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_WriteReg = 0; MEM_ALUOut = 0;
        step(); step();
        checks++;
        if (IF_PCSrc !== 2'b00 || IF_PCWrite !== 1'b1 || IF_Write !== 1'b1
            || IF_Flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch got src=%b pcw=%b w=%b fl=%b exp 00 1 1 0",
                     IF_PCSrc, IF_PCWrite, IF_Write, IF_Flush);
        end
        checks++;
        if (ex_bus.EX_PCplus4 !== 32'hBFC0_0000 || ex_bus.EX_RegWrite !== 1'b0
            || ex_bus.EX_RsData !== 32'h0 || ex_bus.EX_WriteReg !== 5'd0) begin
            errors++;
            $display("FAIL reset_ex got pc4=%h rw=%b rs=%h wr=%0d exp bfc00000 0 0 0",
                     ex_bus.EX_PCplus4, ex_bus.EX_RegWrite, ex_bus.EX_RsData,
                     ex_bus.EX_WriteReg);
        end
        Reset = 1'b0;
        ID_Instruction = 32'h0;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b00 || IF_PCWrite !== 1'b1 || IF_Flush !== 1'b0) begin
            errors++;
            $display("FAIL nop_fetch got src=%b pcw=%b fl=%b exp 00 1 0",
                     IF_PCSrc, IF_PCWrite, IF_Flush);
        end
        step();
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || ex_bus.EX_MemRead !== 0
            || ex_bus.EX_MemWrite !== 0 || ex_bus.EX_PCplus4 !== 32'h4) begin
            errors++;
            $display("FAIL nop_ex got rw=%b mr=%b mw=%b pc4=%h exp 0 0 0 4",
                     ex_bus.EX_RegWrite, ex_bus.EX_MemRead,
                     ex_bus.EX_MemWrite, ex_bus.EX_PCplus4);
        end
    endtask

    task automatic test_wb_bypass();
        ID_Instruction = rtype(8, 0, 9, 6'h20);
        ID_PCplus4 = 32'h10;
        WB_RegWrite = 1; WB_WriteReg = 8; WB_WriteData = 32'h1234;
        step();
        WB_RegWrite = 0;
        checks++;
        if (ex_bus.EX_RsData !== 32'h1234 || ex_bus.EX_WriteReg !== 5'd9
            || ex_bus.EX_RegWrite !== 1'b1 || ex_bus.EX_ALUOp !== 4'd0
            || ex_bus.EX_Rs !== 5'd8) begin
            errors++;
            $display("FAIL wb_first got rs=%h wr=%0d rw=%b op=%0d rsi=%0d exp 1234 9 1 0 8",
                     ex_bus.EX_RsData, ex_bus.EX_WriteReg, ex_bus.EX_RegWrite,
                     ex_bus.EX_ALUOp, ex_bus.EX_Rs);
        end
        ID_Instruction = rtype(8, 8, 10, 6'h22);
        step();
        checks++;
        if (ex_bus.EX_RsData !== 32'h1234 || ex_bus.EX_RtData !== 32'h1234
            || ex_bus.EX_ALUOp !== 4'd1 || ex_bus.EX_WriteReg !== 5'd10) begin
            errors++;
            $display("FAIL rf_hold got rs=%h rt=%h op=%0d wr=%0d exp 1234 1234 1 10",
                     ex_bus.EX_RsData, ex_bus.EX_RtData, ex_bus.EX_ALUOp,
                     ex_bus.EX_WriteReg);
        end
        ID_Instruction = rtype(0, 0, 1, 6'h2A);
        WB_RegWrite = 1; WB_WriteReg = 0; WB_WriteData = 32'hFFFF;
        step();
        WB_RegWrite = 0;
        checks++;
        if (ex_bus.EX_RsData !== 32'h0 || ex_bus.EX_RtData !== 32'h0
            || ex_bus.EX_ALUOp !== 4'd4) begin
            errors++;
            $display("FAIL r0_zero got rs=%h rt=%h op=%0d exp 0 0 4",
                     ex_bus.EX_RsData, ex_bus.EX_RtData, ex_bus.EX_ALUOp);
        end
    endtask

    task automatic test_load_use();
        ID_Instruction = itype(6'h23, 0, 0, 0);
        step();
        ID_Instruction = rtype(0, 0, 9, 6'h20);
        #1;
        checks++;
        if (IF_PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL lw_r0_nostall got pcw=%b exp 1", IF_PCWrite);
        end
        ID_Instruction = itype(6'h23, 0, 8, 0);
        ID_PCplus4 = 32'h20;
        step();
        checks++;
        if (ex_bus.EX_MemRead !== 1 || ex_bus.EX_WriteReg !== 5'd8
            || ex_bus.EX_ALUSrc !== 1 || ex_bus.EX_MemToReg !== 1) begin
            errors++;
            $display("FAIL lw_decode got mr=%b wr=%0d as=%b m2r=%b exp 1 8 1 1",
                     ex_bus.EX_MemRead, ex_bus.EX_WriteReg, ex_bus.EX_ALUSrc,
                     ex_bus.EX_MemToReg);
        end
        ID_Instruction = itype(6'h08, 0, 8, 5);
        #1;
        checks++;
        if (IF_PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL rt_unused_nostall got pcw=%b exp 1", IF_PCWrite);
        end
        ID_Instruction = rtype(8, 8, 9, 6'h20);
        ID_PCplus4 = 32'h24;
        #1;
        checks++;
        if (IF_PCWrite !== 0 || IF_Write !== 0 || IF_Flush !== 0) begin
            errors++;
            $display("FAIL load_use got pcw=%b w=%b fl=%b exp 0 0 0",
                     IF_PCWrite, IF_Write, IF_Flush);
        end
        step();
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || ex_bus.EX_MemRead !== 0
            || ex_bus.EX_WriteReg !== 0 || IF_PCWrite !== 1) begin
            errors++;
            $display("FAIL bubble got rw=%b mr=%b wr=%0d pcw=%b exp 0 0 0 1",
                     ex_bus.EX_RegWrite, ex_bus.EX_MemRead,
                     ex_bus.EX_WriteReg, IF_PCWrite);
        end
        step();
        checks++;
        if (ex_bus.EX_RegWrite !== 1 || ex_bus.EX_WriteReg !== 5'd9) begin
            errors++;
            $display("FAIL add_issue got rw=%b wr=%0d exp 1 9",
                     ex_bus.EX_RegWrite, ex_bus.EX_WriteReg);
        end
    endtask

    task automatic test_branch();
        ID_Instruction = itype(6'h04, 0, 0, 3);
        ID_PCplus4 = 32'h40;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b01 || ID_BranchAddr !== 32'h4C || IF_Flush !== 1) begin
            errors++;
            $display("FAIL beq_taken got src=%b ba=%h fl=%b exp 01 4c 1",
                     IF_PCSrc, ID_BranchAddr, IF_Flush);
        end
        ID_Instruction = itype(6'h05, 0, 0, 3);
        #1;
        checks++;
        if (IF_PCSrc !== 2'b00 || IF_Flush !== 0) begin
            errors++;
            $display("FAIL bne_not got src=%b fl=%b exp 00 0", IF_PCSrc, IF_Flush);
        end
        ID_Instruction = itype(6'h04, 0, 0, 16'hFFFF);
        #1;
        checks++;
        if (ID_BranchAddr !== 32'h3C) begin
            errors++;
            $display("FAIL br_neg got %h exp 3c", ID_BranchAddr);
        end
        ID_Instruction = itype(6'h04, 9, 0, 3);
        #1;
        checks++;
        if (IF_PCWrite !== 0 || IF_PCSrc !== 2'b00 || IF_Flush !== 0) begin
            errors++;
            $display("FAIL br_ex_stall got pcw=%b src=%b fl=%b exp 0 00 0",
                     IF_PCWrite, IF_PCSrc, IF_Flush);
        end
        step();
        ID_Instruction = itype(6'h05, 8, 0, 2);
        ID_PCplus4 = 32'h100;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b01 || ID_BranchAddr !== 32'h108 || IF_PCWrite !== 1) begin
            errors++;
            $display("FAIL bne_taken got src=%b ba=%h pcw=%b exp 01 108 1",
                     IF_PCSrc, ID_BranchAddr, IF_PCWrite);
        end
        step();
    endtask

    task automatic test_jal();
        ID_Instruction = jtype(6'h03, 26'h100);
        ID_PCplus4 = 32'h1000_0008;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b10 || ID_JumpAddr !== 32'h1000_0400 || IF_Flush !== 1) begin
            errors++;
            $display("FAIL jal_fetch got src=%b ja=%h fl=%b exp 10 10000400 1",
                     IF_PCSrc, ID_JumpAddr, IF_Flush);
        end
        step();
        checks++;
        if (ex_bus.EX_WriteReg !== 5'd31 || ex_bus.EX_Link !== 1
            || ex_bus.EX_RegWrite !== 1 || ex_bus.EX_PCplus4 !== 32'h1000_0008) begin
            errors++;
            $display("FAIL jal_ex got wr=%0d lk=%b rw=%b pc4=%h exp 31 1 1 10000008",
                     ex_bus.EX_WriteReg, ex_bus.EX_Link, ex_bus.EX_RegWrite,
                     ex_bus.EX_PCplus4);
        end
        ID_Instruction = jtype(6'h02, 26'h3FF_FFFF);
        ID_PCplus4 = 32'hF000_0000;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b10 || ID_JumpAddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL j_fetch got src=%b ja=%h exp 10 fffffffc",
                     IF_PCSrc, ID_JumpAddr);
        end
        step();
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || ex_bus.EX_Link !== 0) begin
            errors++;
            $display("FAIL j_ex got rw=%b lk=%b exp 0 0",
                     ex_bus.EX_RegWrite, ex_bus.EX_Link);
        end
    endtask

    task automatic test_jr();
        ID_Instruction = rtype(8, 0, 0, 6'h08);
        MEM_RegWrite = 1; MEM_WriteReg = 8; MEM_ALUOut = 32'h80;
        #1;
`ifdef ID_BRANCH_FWD_EN
        checks++;
        if (IF_PCSrc !== 2'b11 || ID_RsData !== 32'h80 || IF_PCWrite !== 1
            || IF_Flush !== 1) begin
            errors++;
            $display("FAIL jr_fwd got src=%b rs=%h pcw=%b fl=%b exp 11 80 1 1",
                     IF_PCSrc, ID_RsData, IF_PCWrite, IF_Flush);
        end
`else
        checks++;
        if (IF_PCWrite !== 0 || IF_PCSrc !== 2'b00 || IF_Flush !== 0) begin
            errors++;
            $display("FAIL jr_stall got pcw=%b src=%b fl=%b exp 0 00 0",
                     IF_PCWrite, IF_PCSrc, IF_Flush);
        end
`endif
        step();
        MEM_RegWrite = 0; MEM_WriteReg = 0;
        WB_RegWrite = 1; WB_WriteReg = 8; WB_WriteData = 32'h80;
        #1;
        checks++;
        if (IF_PCSrc !== 2'b11 || ID_RsData !== 32'h80 || IF_PCWrite !== 1) begin
            errors++;
            $display("FAIL jr_wb got src=%b rs=%h pcw=%b exp 11 80 1",
                     IF_PCSrc, ID_RsData, IF_PCWrite);
        end
        step();
        WB_RegWrite = 0;
        MEM_RegWrite = 1; MEM_MemRead = 1; MEM_WriteReg = 8;
        #1;
        checks++;
        if (IF_PCWrite !== 0 || IF_PCSrc !== 2'b00) begin
            errors++;
            $display("FAIL jr_memload got pcw=%b src=%b exp 0 00", IF_PCWrite, IF_PCSrc);
        end
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_WriteReg = 0;
        step();
    endtask

    task automatic test_back_to_back();
        ID_Instruction = itype(6'h23, 0, 8, 0);
        step();
        ID_Instruction = itype(6'h04, 8, 0, 1);
        ID_PCplus4 = 32'h200;
        #1;
        checks++;
        if (IF_PCWrite !== 0 || IF_Flush !== 0 || IF_PCSrc !== 2'b00) begin
            errors++;
            $display("FAIL b2b_stall1 got pcw=%b fl=%b src=%b exp 0 0 00",
                     IF_PCWrite, IF_Flush, IF_PCSrc);
        end
        step();
        MEM_RegWrite = 1; MEM_MemRead = 1; MEM_WriteReg = 8;
        #1;
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || ex_bus.EX_MemRead !== 0 || IF_Write !== 0) begin
            errors++;
            $display("FAIL b2b_stall2 got rw=%b mr=%b w=%b exp 0 0 0",
                     ex_bus.EX_RegWrite, ex_bus.EX_MemRead, IF_Write);
        end
        step();
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_WriteReg = 0;
        WB_RegWrite = 1; WB_WriteReg = 8; WB_WriteData = 32'h0;
        #1;
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || IF_PCWrite !== 1 || IF_PCSrc !== 2'b01
            || ID_BranchAddr !== 32'h204) begin
            errors++;
            $display("FAIL b2b_release got rw=%b pcw=%b src=%b ba=%h exp 0 1 01 204",
                     ex_bus.EX_RegWrite, IF_PCWrite, IF_PCSrc, ID_BranchAddr);
        end
        step();
        WB_RegWrite = 0;
    endtask

    task automatic test_imm();
        ID_Instruction = itype(6'h0C, 0, 3, 16'h8000);
        step();
        checks++;
        if (ex_bus.EX_Imm !== 32'h0000_8000 || ex_bus.EX_ALUSrc !== 1
            || ex_bus.EX_WriteReg !== 5'd3 || ex_bus.EX_ALUOp !== 4'd2) begin
            errors++;
            $display("FAIL andi got imm=%h as=%b wr=%0d op=%0d exp 00008000 1 3 2",
                     ex_bus.EX_Imm, ex_bus.EX_ALUSrc, ex_bus.EX_WriteReg,
                     ex_bus.EX_ALUOp);
        end
        ID_Instruction = itype(6'h08, 0, 4, 16'h8000);
        step();
        checks++;
        if (ex_bus.EX_Imm !== 32'hFFFF_8000 || ex_bus.EX_RegWrite !== 1) begin
            errors++;
            $display("FAIL addi got imm=%h rw=%b exp ffff8000 1",
                     ex_bus.EX_Imm, ex_bus.EX_RegWrite);
        end
        ID_Instruction = itype(6'h2B, 0, 5, 4);
        step();
        checks++;
        if (ex_bus.EX_MemWrite !== 1 || ex_bus.EX_RegWrite !== 0
            || ex_bus.EX_Imm !== 32'h4) begin
            errors++;
            $display("FAIL sw got mw=%b rw=%b imm=%h exp 1 0 4",
                     ex_bus.EX_MemWrite, ex_bus.EX_RegWrite, ex_bus.EX_Imm);
        end
        ID_Instruction = itype(6'h3F, 1, 2, 7);
        step();
        checks++;
        if (ex_bus.EX_RegWrite !== 0 || ex_bus.EX_MemWrite !== 0
            || ex_bus.EX_MemRead !== 0) begin
            errors++;
            $display("FAIL illegal_nop got rw=%b mw=%b mr=%b exp 0 0 0",
                     ex_bus.EX_RegWrite, ex_bus.EX_MemWrite, ex_bus.EX_MemRead);
        end
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_branch();
        test_jal();
        test_jr();
        test_back_to_back();
        test_imm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline. It consumes ID_Instruction/ID_PCplus4 from the fetch stage and feeds the execute stage.
- Holds the 32x32 register file and decodes control signals.
- Resolves branches and jumps in ID and drives the fetch controls (IF_PCSrc, ID_JumpAddr, ID_BranchAddr, ID_RsData, IF_PCWrite, IF_Write, IF_Flush).
- Registers all execute-stage operands and controls into the ID/EX pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into EX_PCplus4 on reset.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- ID_Instruction  in  32  instruction from fetch
- ID_PCplus4  in  32  PC+4 of that instruction
- WB_RegWrite  in  1  write-back enable
- WB_WriteReg  in  5  write-back destination
- WB_WriteData  in  32  write-back data
- MEM_RegWrite  in  1  MEM stage writes a register
- MEM_MemRead  in  1  MEM stage is a load
- MEM_WriteReg  in  5  MEM stage destination
- MEM_ALUOut  in  32  MEM stage ALU result
- IF_PCSrc  out  2  00 PC+4, 01 branch, 10 jump, 11 register (jr)
- ID_JumpAddr  out  32  {ID_PCplus4[31:28], instr[25:0], 2'b00}
- ID_BranchAddr  out  32  ID_PCplus4 + (sext(imm16) << 2), mod 2^32
- ID_RsData  out  32  resolved rs value, used as the jr target
- IF_PCWrite, IF_Write  out  1 each  deasserted (0) on stall
- IF_Flush  out  1  squashes the instruction being fetched
- EX_RsData, EX_RtData, EX_Imm, EX_PCplus4  out  32 each  registered operands; EX_Imm is sign- or zero-extended per opcode
- EX_Rs, EX_Rt, EX_WriteReg  out  5 each  registered register indices
- EX_ALUOp  out  4  registered ALU operation
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_Link  out  1 each  registered controls

Behaviour:
- Supported instructions:
  - R-type: add, sub, and, or, slt, sll, srl, jr
  - I-type and jumps: addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal
  - Any other encoding, and 32'h0, decodes as a NOP: all write/mem controls 0.
- Register file:
  - r0 always reads 0 and ignores writes.
  - Write happens on the Clock edge when WB_RegWrite=1.
  - Reads are write-first: a same-cycle WB write to the same index returns WB_WriteData.
  - All 32 registers clear on Reset.
- Reset: every EX_ output clears to 0, except EX_PCplus4 = RESET_PC. This is a bubble.
- Fetch controls are combinational. While Reset is high: IF_PCSrc=00, IF_PCWrite=1, IF_Write=1, IF_Flush=0.
- Load-use stall:
  - Condition: EX_MemRead=1, EX_WriteReg≠0, and EX_WriteReg matches a source register actually used (rs; rt only for R-type, sw, beq, bne).
  - Response: IF_PCWrite=0, IF_Write=0, bubble into ID/EX.
- Branch/jr operand stall:
  - Applies to beq, bne and jr.
  - Stall if EX_RegWrite=1 with EX_WriteReg≠0 matching rs/rt (operand not yet computed).
  - Also stall if MEM_MemRead=1 with MEM_WriteReg matching rs/rt.
- Stall has priority over redirect: while stalled, IF_PCSrc=00 and IF_Flush=0.
- Redirect (when not stalled):
  - beq taken, or bne taken → PCSrc=01
  - j or jal → PCSrc=10
  - jr → PCSrc=11
  - Every redirect asserts IF_Flush=1 for that cycle (delay slot squashed).
  - Not-taken branch → PCSrc=00, IF_Flush=0.
- jal: EX_WriteReg=31, EX_Link=1, EX_RegWrite=1. The link value EX_PCplus4 is the jal's ID_PCplus4.
- Destination: EX_WriteReg = rd for R-type, rt for I-type loads and ALU ops.
- A stall lasts exactly as long as its condition holds. Back-to-back stalls insert consecutive bubbles. The ID instruction is held by fetch (IF_Write=0).

Optional Feature:
- Macro: ID_BRANCH_FWD_EN.
- Defined: branch/jr operands are bypassed from MEM_ALUOut when MEM_RegWrite=1, MEM_MemRead=0, MEM_WriteReg≠0 and MEM_WriteReg matches; no stall in that case.
- Undefined: that case also stalls until the value reaches the register file through WB.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams
  - ALUOp encodings
  - IF_PCSrc encodings (PCSRC_SEQ/BR/JMP/JR)
  - a NOP constant
- Sub-module reg_file: 32x32, 2 read ports, 1 write port, write-first, synchronous clear.

Test Plan:
- Reset, then ID_Instruction=32'h0 → all EX_ controls 0, IF_PCSrc=00, IF_PCWrite=1, IF_Flush=0.
- WB writes r8=32'h1234 while ID holds add $9,$8,$0 → next cycle EX_RsData=32'h1234, EX_WriteReg=9, EX_RegWrite=1 (write-first bypass).
- lw $8,0($0) in EX, ID=add $9,$8,$8 → IF_PCWrite=0 and IF_Write=0 for 1 cycle, bubble in EX, then add issues.
- ID=beq $0,$0,+3 with ID_PCplus4=32'h40 → IF_PCSrc=01, ID_BranchAddr=32'h4C, IF_Flush=1. bne $0,$0 → PCSrc=00, IF_Flush=0.
- ID=jal 0x100 with ID_PCplus4=32'h1000_0008 → PCSrc=10, ID_JumpAddr=32'h1000_0400, then EX_WriteReg=31, EX_PCplus4=32'h1000_0008.
- ID=jr $8 with MEM_RegWrite=1, MEM_WriteReg=8, MEM_ALUOut=32'h80 → with ID_BRANCH_FWD_EN: PCSrc=11, ID_RsData=32'h80, no stall. Without the macro: stall until the WB write.
